// File: rtl/div_pow2_pkg.sv
// Shared definitions for the signed power-of-two divider: default width,
// the stage-payload struct pattern and the legal-shift assertion text.
package div_pow2_pkg;

   localparam int DEFAULT_N = 8;

endpackage

// Expands to the stage-1 payload struct for a given dividend and shift width.
`define DIV_POW2_STAGE_T(W, SWD) \
   struct packed { \
      logic            valid; \
      logic [W-1:0]    a; \
      logic [SWD-1:0]  sh; \
      logic [W-1:0]    b; \
   }

`define DIV_POW2_ASSERT_LEGAL_SH(CLK, EN, SH, LIM) \
   assert property (@(posedge CLK) (EN) |-> (int'(SH) < (LIM)));

// File: rtl/arith_shift_right_var.sv
// Combinational variable arithmetic right shift; rounds toward minus infinity,
// exactly like the >>> operator on a signed operand.
module arith_shift_right_var #(
   parameter int N  = 8,
   parameter int SW = $clog2(N)
) (
   input  logic [N-1:0]  a,
   input  logic [SW-1:0] sh,
   output logic [N-1:0]  y
);

   assign y = $signed(a) >>> sh;

endmodule

// File: rtl/signed_div_pow2_pipe.sv
// Two-stage valid/ready signed divide by 2**sh, truncating toward zero.
// Define SIGNED_DIV_POW2_REMAINDER_EN to build the remainder path; otherwise down_r is 0.
module signed_div_pow2_pipe
   import div_pow2_pkg::*;
#(
   parameter int N  = DEFAULT_N,
   parameter int SW = $clog2(N)
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          up_valid,
   output logic          up_ready,
   input  logic [N-1:0]  up_a,
   input  logic [SW-1:0] up_sh,
   output logic          down_valid,
   input  logic          down_ready,
   output logic [N-1:0]  down_q,
   output logic [N-1:0]  down_r
);

   typedef `DIV_POW2_STAGE_T(N, SW) stage_t;

   localparam logic [N-1:0] ONE = N'(1);

   stage_t         s1;
   logic           s2_valid;
   logic [N-1:0]   s2_q;
   logic           s1_load;
   logic           s2_load;
   logic           up_fire;
   logic [N-1:0]   bias;
   logic [N-1:0]   b_next;
   logic [N-1:0]   q_next;

   assign s2_load  = !s2_valid || down_ready;
   assign s1_load  = !s1.valid || s2_load;
   assign up_ready = s1_load;
   assign up_fire  = up_valid && up_ready;

   // Negative dividends get 2**sh-1 added so the later floor shift truncates toward zero.
   assign bias   = up_a[N-1] ? ((ONE << up_sh) - ONE) : '0;
   assign b_next = up_a + bias;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         s1 <= '0;
      end else if (s1_load) begin
         s1.valid <= up_valid;
         if (up_valid) begin
            s1.a  <= up_a;
            s1.sh <= up_sh;
            s1.b  <= b_next;
         end
      end
   end

   arith_shift_right_var #(
      .N  (N),
      .SW (SW)
   ) u_shift (
      .a  (s1.b),
      .sh (s1.sh),
      .y  (q_next)
   );

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         s2_valid <= 1'b0;
         s2_q     <= '0;
      end else if (s2_load) begin
         s2_valid <= s1.valid;
         if (s1.valid) begin
            s2_q <= q_next;
         end
      end
   end

   assign down_valid = s2_valid;
   assign down_q     = s2_q;

`ifdef SIGNED_DIV_POW2_REMAINDER_EN
   logic [N-1:0] s2_r;
   logic [N-1:0] r_next;

   assign r_next = s1.a - (q_next << s1.sh);

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         s2_r <= '0;
      end else if (s2_load && s1.valid) begin
         s2_r <= r_next;
      end
   end

   assign down_r = s2_r;
`else
   logic unused_a;

   assign unused_a = ^s1.a;
   assign down_r   = '0;
`endif

`ifndef SYNTHESIS
   `DIV_POW2_ASSERT_LEGAL_SH(clk, rst_n && up_fire, up_sh, N)
`endif

endmodule

// File: tb/tb_signed_div_pow2_pipe.sv
// Directed and randomised self-checking bench for signed_div_pow2_pipe (N = 8).
module tb_signed_div_pow2_pipe;

   logic       clk;
   logic       rst_n;
   logic       up_valid;
   logic       up_ready;
   logic [7:0] up_a;
   logic [2:0] up_sh;
   logic       down_valid;
   logic       down_ready;
   logic [7:0] down_q;
   logic [7:0] down_r;

   int checks = 0;
   int errors = 0;

   signed_div_pow2_pipe #(
      .N  (8),
      .SW (3)
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .up_valid   (up_valid),
      .up_ready   (up_ready),
      .up_a       (up_a),
      .up_sh      (up_sh),
      .down_valid (down_valid),
      .down_ready (down_ready),
      .down_q     (down_q),
      .down_r     (down_r)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic checkOutput(input string tag, input logic [7:0] got, input logic [7:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("[TB] FAIL %s got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic applyStimulus(input logic v, input logic [7:0] a, input logic [2:0] sh,
                                input logic dr);
      up_valid   = v;
      up_a       = a;
      up_sh      = sh;
      down_ready = dr;
      #1;
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [7:0] expR(input logic [7:0] r);
`ifdef SIGNED_DIV_POW2_REMAINDER_EN
      return r;
`else
      return (r & 8'h00);
`endif
   endfunction

   // Directed vectors: dividend, shift, hand-computed quotient and remainder.
   int vecA  [8] = '{-9, -8, -1, 9, -128, -128, 127, -127};
   int vecSh [8] = '{ 3,  3,  3, 3,    7,    0,   7,    7};
   int vecQ  [8] = '{-1, -1,  0, 1,   -1, -128,   0,    0};
   int vecR  [8] = '{-1,  0, -1, 1,    0,    0, 127, -127};

   logic [7:0] expQ [$];
   logic [7:0] expRq[$];

   initial begin
      rst_n = 1'b0;
      applyStimulus(1'b1, 8'hF7, 3'd3, 1'b1);

      $display("[TB] reset held with up_valid high");
      for (int i = 0; i < 3; i++) begin
         step();
         checkOutput("rst_dv", 8'(down_valid), 8'd0);
         checkOutput("rst_q", down_q, 8'd0);
         checkOutput("rst_r", down_r, 8'd0);
         checkOutput("rst_ur", 8'(up_ready), 8'd1);
      end
      rst_n = 1'b1;
      applyStimulus(1'b0, 8'h00, 3'd0, 1'b1);
      for (int i = 0; i < 3; i++) begin
         step();
         checkOutput("post_rst_dv", 8'(down_valid), 8'd0);
      end

      $display("[TB] back-to-back rounding and extremes");
      for (int c = 0; c < 9; c++) begin
         if (c < 8) applyStimulus(1'b1, 8'(vecA[c]), 3'(vecSh[c]), 1'b1);
         else       applyStimulus(1'b0, 8'h00, 3'd0, 1'b1);
         checkOutput("stream_ur", 8'(up_ready), 8'd1);
         step();
         if (c == 0) begin
            checkOutput("lat_dv", 8'(down_valid), 8'd0);
         end else begin
            checkOutput("stream_dv", 8'(down_valid), 8'd1);
            checkOutput("stream_q", down_q, 8'(vecQ[c-1]));
            checkOutput("stream_r", down_r, expR(8'(vecR[c-1])));
         end
      end
      step();
      checkOutput("stream_end_dv", 8'(down_valid), 8'd0);

      $display("[TB] backpressure");
      applyStimulus(1'b1, 8'd50, 3'd2, 1'b0);
      checkOutput("bp_ur0", 8'(up_ready), 8'd1);
      step();
      applyStimulus(1'b1, 8'hCE, 3'd2, 1'b0);
      checkOutput("bp_ur1", 8'(up_ready), 8'd1);
      step();
      applyStimulus(1'b1, 8'hF9, 3'd1, 1'b0);
      for (int i = 0; i < 2; i++) begin
         checkOutput("bp_full_ur", 8'(up_ready), 8'd0);
         checkOutput("bp_hold_dv", 8'(down_valid), 8'd1);
         checkOutput("bp_hold_q", down_q, 8'd12);
         checkOutput("bp_hold_r", down_r, expR(8'd2));
         step();
      end
      applyStimulus(1'b1, 8'hF9, 3'd1, 1'b1);
      checkOutput("bp_rel_ur", 8'(up_ready), 8'd1);
      checkOutput("bp_q0", down_q, 8'd12);
      step();
      applyStimulus(1'b0, 8'h00, 3'd0, 1'b1);
      checkOutput("bp_dv1", 8'(down_valid), 8'd1);
      checkOutput("bp_q1", down_q, 8'hF4);
      checkOutput("bp_r1", down_r, expR(8'hFE));
      step();
      checkOutput("bp_dv2", 8'(down_valid), 8'd1);
      checkOutput("bp_q2", down_q, 8'hFD);
      checkOutput("bp_r2", down_r, expR(8'hFF));
      step();
      checkOutput("bp_nodup_dv", 8'(down_valid), 8'd0);

      $display("[TB] reset with two samples in flight");
      applyStimulus(1'b1, 8'd100, 3'd1, 1'b0);
      step();
      applyStimulus(1'b1, 8'd20, 3'd2, 1'b0);
      step();
      checkOutput("mid_full_dv", 8'(down_valid), 8'd1);
      rst_n = 1'b0;
      applyStimulus(1'b0, 8'h00, 3'd0, 1'b1);
      step();
      checkOutput("mid_rst_dv", 8'(down_valid), 8'd0);
      checkOutput("mid_rst_q", down_q, 8'd0);
      checkOutput("mid_rst_ur", 8'(up_ready), 8'd1);
      rst_n = 1'b1;
      for (int i = 0; i < 3; i++) begin
         step();
         checkOutput("mid_after_dv", 8'(down_valid), 8'd0);
      end

      $display("[TB] random traffic");
      for (int n = 0; n < 10000; n++) begin
         logic [7:0] ra;
         logic [2:0] rs;
         ra = 8'($urandom);
         rs = 3'($urandom_range(0, 7));
         applyStimulus(($urandom_range(0, 3) != 0), ra, rs, ($urandom_range(0, 9) < 7));
         if (down_valid && down_ready) begin
            if (expQ.size() == 0) begin
               checkOutput("rnd_spurious", 8'd1, 8'd0);
            end else begin
               checkOutput("rnd_q", down_q, expQ.pop_front());
               checkOutput("rnd_r", down_r, expRq.pop_front());
            end
         end
         if (up_valid && up_ready) begin
            int sa;
            int d;
            sa = int'($signed(ra));
            d  = 1 << rs;
            expQ.push_back(8'(sa / d));
            expRq.push_back(expR(8'(sa % d)));
         end
         step();
      end
      for (int n = 0; n < 10 && expQ.size() != 0; n++) begin
         applyStimulus(1'b0, 8'h00, 3'd0, 1'b1);
         if (down_valid) begin
            checkOutput("drain_q", down_q, expQ.pop_front());
            checkOutput("drain_r", down_r, expRq.pop_front());
         end
         step();
      end
      checkOutput("drain_left", 8'(expQ.size()), 8'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
